encr_rx_buf_reader: RTL and testbench

ENCR_RX_BUF_READER -- requirements
Module: encr_rx_buf_reader

---
 rtl/encr_rx_buf_reader_pkg.sv | 20 ++
 rtl/encr_rx_rd_pipe.sv | 34 +++
 rtl/encr_rx_buf_reader.sv | 219 +++++++++++++++++++++
 tb/tb_encr_rx_buf_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encr_rx_buf_reader_pkg.sv
// Shared types and constants for the encryption RX buffer reader.
// Optional MIC extraction is enabled with RW_RX_MIC_EXTRACT_EN.
package encr_rx_buf_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

  localparam int unsigned MIC_LEN    = 8;
  localparam int unsigned WORD_BYTES = 4;

  // Bytes to gather for the next word: a full word or whatever is left.
  function automatic logic [3:0] word_need(input logic [31:0] bytes_left);
    return (bytes_left >= WORD_BYTES) ? 4'(WORD_BYTES) : bytes_left[3:0];
  endfunction

endpackage

// File: rtl/encr_rx_rd_pipe.sv
// Tracks pops whose read data has not yet returned from the buffer RAM.
// cap marks the cycle a popped byte is valid on the read-data bus.
module encr_rx_rd_pipe #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic       bbClk,
  input  logic       hardRstBbClk_n,
  input  logic       clr,
  input  logic       pop,
  output logic       cap,
  output logic [1:0] inflight
);

  logic [RD_LATENCY-1:0] tags;

  always_ff @(posedge bbClk or negedge hardRstBbClk_n) begin
    if (!hardRstBbClk_n) begin
      tags <= '0;
    end else if (clr) begin
      tags <= '0;
    end else begin
      tags[0] <= pop;
      for (int unsigned i = 1; i < RD_LATENCY; i++) tags[i] <= tags[i-1];
    end
  end

  assign cap = tags[RD_LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) inflight = inflight + {1'b0, tags[i]};
  end

endmodule

// File: rtl/encr_rx_buf_reader.sv
// Reads a packet byte-wise from the encryption RX buffer and packs it into 32-bit words.
// With RW_RX_MIC_EXTRACT_EN the trailing 8 bytes are diverted to micData.
module encr_rx_buf_reader
  import encr_rx_buf_reader_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned PKT_LEN_W  = 16
) (
  input  logic                 bbClk,
  input  logic                 hardRstBbClk_n,
  input  logic                 softRstBbClk_p,
  input  logic                 startRead_p,
  input  logic [PKT_LEN_W-1:0] rxPayloadLen,
  input  logic                 encrRxBufFlush_p,
  input  logic                 bufferEmptyFlag,
  output logic                 popDataOutBuffer_p,
  input  logic [7:0]           readDataEncrRxBuffer,
  output logic [31:0]          wordData,
  output logic [3:0]           wordByteEn,
  output logic                 wordValid,
  input  logic                 wordReady,
  output logic                 wordLast,
  output logic                 readDone_p,
`ifdef RW_RX_MIC_EXTRACT_EN
  output logic [63:0]          micData,
  output logic                 micValid,
  output logic                 lenError_p,
`endif
  output logic                 busy
);

  rd_state_e            state, state_nx;
  logic [PKT_LEN_W-1:0] data_rem, data_len_in;
  logic [3:0]           cap_cnt, need, load_need, issued;
  logic [31:0]          word_data;
  logic [3:0]           byte_en;
  logic                 word_last;
  logic                 clr, pop, load, cap, fill_done;
  logic [1:0]           inflight;
`ifdef RW_RX_MIC_EXTRACT_EN
  logic                 mic_split, in_mic, load_mic, mic_ok, len_err;
  logic [3:0]           mic_rem;
  logic [63:0]          mic_data;
`endif

  assign clr = softRstBbClk_p | encrRxBufFlush_p;

`ifdef RW_RX_MIC_EXTRACT_EN
  assign mic_split   = rxPayloadLen >= PKT_LEN_W'(MIC_LEN);
  assign data_len_in = mic_split ? rxPayloadLen - PKT_LEN_W'(MIC_LEN) : rxPayloadLen;
`else
  assign data_len_in = rxPayloadLen;
`endif

  encr_rx_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_pipe (
    .bbClk          (bbClk),
    .hardRstBbClk_n (hardRstBbClk_n),
    .clr            (clr),
    .pop            (pop),
    .cap            (cap),
    .inflight       (inflight)
  );

  // In-flight pops count toward the word so the pipe never over-reads.
  assign issued    = cap_cnt + {2'b00, inflight};
  assign fill_done = cap && (cap_cnt + 4'd1 == need);

  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    load      = 1'b0;
    load_need = '0;
`ifdef RW_RX_MIC_EXTRACT_EN
    load_mic  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (startRead_p) begin
          if (rxPayloadLen == '0) begin
            state_nx = ST_DONE;
          end else if (data_len_in != '0) begin
            state_nx  = ST_FILL;
            load      = 1'b1;
            load_need = word_need(32'(data_len_in));
          end
`ifdef RW_RX_MIC_EXTRACT_EN
          else begin
            state_nx  = ST_FILL;
            load      = 1'b1;
            load_mic  = 1'b1;
            load_need = 4'(MIC_LEN);
          end
`endif
        end
      end
      ST_FILL: begin
        pop = !bufferEmptyFlag && (issued < need);
        if (fill_done) begin
`ifdef RW_RX_MIC_EXTRACT_EN
          state_nx = in_mic ? ST_DONE : ST_OUT;
`else
          state_nx = ST_OUT;
`endif
        end
      end
      ST_OUT: begin
        if (wordReady) begin
          if (data_rem != '0) begin
            state_nx  = ST_FILL;
            load      = 1'b1;
            load_need = word_need(32'(data_rem));
          end
`ifdef RW_RX_MIC_EXTRACT_EN
          else if (mic_rem != '0) begin
            state_nx  = ST_FILL;
            load      = 1'b1;
            load_mic  = 1'b1;
            load_need = mic_rem;
          end
`endif
          else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (clr) begin
      state_nx = ST_IDLE;
      pop      = 1'b0;
      load     = 1'b0;
    end
  end

  always_ff @(posedge bbClk or negedge hardRstBbClk_n) begin
    if (!hardRstBbClk_n) begin
      state     <= ST_IDLE;
      data_rem  <= '0;
      cap_cnt   <= '0;
      need      <= '0;
      word_data <= '0;
      byte_en   <= '0;
      word_last <= 1'b0;
`ifdef RW_RX_MIC_EXTRACT_EN
      in_mic    <= 1'b0;
      mic_rem   <= '0;
      mic_data  <= '0;
      mic_ok    <= 1'b0;
      len_err   <= 1'b0;
`endif
    end else if (clr) begin
      state     <= ST_IDLE;
      data_rem  <= '0;
      cap_cnt   <= '0;
      need      <= '0;
      word_data <= '0;
      byte_en   <= '0;
      word_last <= 1'b0;
`ifdef RW_RX_MIC_EXTRACT_EN
      in_mic    <= 1'b0;
      mic_rem   <= '0;
      mic_data  <= '0;
      mic_ok    <= 1'b0;
      len_err   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && startRead_p) begin
        data_rem <= data_len_in;
`ifdef RW_RX_MIC_EXTRACT_EN
        mic_rem  <= mic_split ? 4'(MIC_LEN) : '0;
        mic_ok   <= mic_split;
        len_err  <= !mic_split;
        mic_data <= '0;
`endif
      end
      if (load) begin
        cap_cnt   <= '0;
        need      <= load_need;
        word_data <= '0;
        byte_en   <= '0;
        word_last <= 1'b0;
`ifdef RW_RX_MIC_EXTRACT_EN
        in_mic    <= load_mic;
`endif
      end else if (state == ST_FILL && cap) begin
        cap_cnt <= cap_cnt + 4'd1;
`ifdef RW_RX_MIC_EXTRACT_EN
        if (in_mic) begin
          mic_data[{cap_cnt[2:0], 3'b000} +: 8] <= readDataEncrRxBuffer;
          if (mic_rem != '0) mic_rem <= mic_rem - 4'd1;
        end else begin
`endif
          word_data[{cap_cnt[1:0], 3'b000} +: 8] <= readDataEncrRxBuffer;
          byte_en[cap_cnt[1:0]]                  <= 1'b1;
          if (data_rem != '0) data_rem <= data_rem - PKT_LEN_W'(1);
          if (fill_done) word_last <= (data_rem == PKT_LEN_W'(1));
`ifdef RW_RX_MIC_EXTRACT_EN
        end
`endif
      end
    end
  end

  assign popDataOutBuffer_p = pop;
  assign wordData           = word_data;
  assign wordByteEn         = byte_en;
  assign wordValid          = (state == ST_OUT);
  assign wordLast           = word_last && (state == ST_OUT);
  assign readDone_p         = (state == ST_DONE);
  assign busy               = (state != ST_IDLE);
`ifdef RW_RX_MIC_EXTRACT_EN
  assign micData            = mic_data;
  assign micValid           = (state == ST_DONE) && mic_ok;
  assign lenError_p         = (state == ST_DONE) && len_err;
`endif

endmodule

// File: tb/tb_encr_rx_buf_reader.sv
// Scoreboard bench for encr_rx_buf_reader; buffer RAM modelled with one-cycle read latency.
// Also exercises MIC extraction when RW_RX_MIC_EXTRACT_EN is defined.
module tb_encr_rx_buf_reader;

  logic        bbClk = 1'b0;
  logic        hardRstBbClk_n, softRstBbClk_p, startRead_p, encrRxBufFlush_p;
  logic        bufferEmptyFlag, wordReady;
  logic [15:0] rxPayloadLen;
  logic        popDataOutBuffer_p;
  logic [7:0]  readDataEncrRxBuffer = 8'h00;
  logic [31:0] wordData;
  logic [3:0]  wordByteEn;
  logic        wordValid, wordLast, readDone_p, busy;
`ifdef RW_RX_MIC_EXTRACT_EN
  logic [63:0] micData;
  logic        micValid, lenError_p;
  logic [63:0] exp_mic;
  logic        exp_mic_valid, exp_len_err;
`endif

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } exp_word_t;

  exp_word_t   exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  int          exp_done = 0;
  int unsigned pop_count = 0;
  int unsigned pop_mark = 0;
  logic [7:0]  pkt_base = 8'h00;

  always #5 bbClk = ~bbClk;

  encr_rx_buf_reader #(.RD_LATENCY(1), .PKT_LEN_W(16)) dut (
    .bbClk                (bbClk),
    .hardRstBbClk_n       (hardRstBbClk_n),
    .softRstBbClk_p       (softRstBbClk_p),
    .startRead_p          (startRead_p),
    .rxPayloadLen         (rxPayloadLen),
    .encrRxBufFlush_p     (encrRxBufFlush_p),
    .bufferEmptyFlag      (bufferEmptyFlag),
    .popDataOutBuffer_p   (popDataOutBuffer_p),
    .readDataEncrRxBuffer (readDataEncrRxBuffer),
    .wordData             (wordData),
    .wordByteEn           (wordByteEn),
    .wordValid            (wordValid),
    .wordReady            (wordReady),
    .wordLast             (wordLast),
    .readDone_p           (readDone_p),
`ifdef RW_RX_MIC_EXTRACT_EN
    .micData              (micData),
    .micValid             (micValid),
    .lenError_p           (lenError_p),
`endif
    .busy                 (busy)
  );

  // Buffer RAM: byte n of the current packet reads as pkt_base + n, one cycle after its pop.
  always @(posedge bbClk) begin
    if (popDataOutBuffer_p) begin
      readDataEncrRxBuffer <= pkt_base + 8'(pop_count - pop_mark);
      pop_count            <= pop_count + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_word_t e;
    forever begin
      @(negedge bbClk);
      if (wordValid && wordReady) begin
        if (exp_q.size() == 0) begin
          check("word_unexpected", 64'(wordValid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("word_data", 64'(wordData), 64'(e.data));
          check("word_byte_en", 64'(wordByteEn), 64'(e.be));
          check("word_last", 64'(wordLast), 64'(e.last));
        end
      end
      if (readDone_p) begin
        done_seen++;
`ifdef RW_RX_MIC_EXTRACT_EN
        check("mic_valid", 64'(micValid), 64'(exp_mic_valid));
        check("len_error", 64'(lenError_p), 64'(exp_len_err));
        if (exp_mic_valid) check("mic_data", micData, exp_mic);
`endif
      end
    end
  endtask

  task automatic expect_pkt(input int len, input logic [7:0] base);
    int        dlen;
    exp_word_t e;
    dlen = len;
`ifdef RW_RX_MIC_EXTRACT_EN
    exp_mic_valid = (len >= 8);
    exp_len_err   = (len < 8);
    exp_mic       = '0;
    if (len >= 8) begin
      dlen = len - 8;
      for (int i = 0; i < 8; i++) exp_mic[i*8 +: 8] = base + 8'(dlen + i);
    end
`endif
    for (int w = 0; w * 4 < dlen; w++) begin
      e.data = '0;
      e.be   = '0;
      for (int l = 0; l < 4; l++) begin
        if (w * 4 + l < dlen) begin
          e.data[l*8 +: 8] = base + 8'(w * 4 + l);
          e.be[l]          = 1'b1;
        end
      end
      e.last = ((w + 1) * 4 >= dlen);
      exp_q.push_back(e);
    end
    exp_done++;
  endtask

  task automatic start_pkt(input int len, input logic [7:0] base, input bit expect_it);
    pkt_base = base;
    pop_mark = pop_count;
    if (expect_it) expect_pkt(len, base);
    rxPayloadLen = 16'(len);
    startRead_p  = 1'b1;
    @(posedge bbClk); #1;
    startRead_p  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!readDone_p && n < budget) begin
      @(posedge bbClk); #1;
      n++;
    end
    if (!readDone_p) check("done_timeout", 64'(readDone_p), 64'(1));
    repeat (2) @(posedge bbClk);
    #1;
  endtask

  task automatic wait_pops(input int unsigned npops, input int budget);
    int n = 0;
    while ((pop_count - pop_mark) < npops && n < budget) begin
      @(posedge bbClk); #1;
      n++;
    end
    check("pop_wait", 64'(pop_count - pop_mark), 64'(npops));
  endtask

  task automatic end_pkt(input int len);
    check("pop_count", 64'(pop_count - pop_mark), 64'(len));
    check("done_count", 64'(done_seen), 64'(exp_done));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none

    hardRstBbClk_n   = 1'b0;
    softRstBbClk_p   = 1'b0;
    startRead_p      = 1'b0;
    encrRxBufFlush_p = 1'b0;
    bufferEmptyFlag  = 1'b0;
    wordReady        = 1'b1;
    rxPayloadLen     = '0;
    repeat (3) @(posedge bbClk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pop", 64'(popDataOutBuffer_p), 64'(0));
    check("rst_valid", 64'(wordValid), 64'(0));
    check("rst_done", 64'(readDone_p), 64'(0));
    check("rst_data", 64'(wordData), 64'(0));
    check("rst_byte_en", 64'(wordByteEn), 64'(0));
    hardRstBbClk_n = 1'b1;
    @(posedge bbClk); #1;

    // len=8 streaming, plus a start pulse while busy that must be ignored
    start_pkt(8, 8'h00, 1'b1);
    repeat (2) @(posedge bbClk);
    #1;
    rxPayloadLen = 16'd3;
    startRead_p  = 1'b1;
    @(posedge bbClk); #1;
    startRead_p  = 1'b0;
    wait_done(100);
    end_pkt(8);

    // len=5 with the sink stalled for 10 cycles on the first word
    wordReady = 1'b0;
    start_pkt(5, 8'h10, 1'b1);
    for (int n = 0; n < 100 && !wordValid; n++) begin
      @(posedge bbClk); #1;
    end
    check("stall_valid_seen", 64'(wordValid), 64'(1));
    for (int c = 0; c < 10; c++) begin
      @(posedge bbClk); #1;
      check("stall_valid", 64'(wordValid), 64'(1));
      check("stall_data", 64'(wordData), 64'h13121110);
      check("stall_pops", 64'(pop_count - pop_mark), 64'(4));
    end
    wordReady = 1'b1;
    wait_done(100);
    end_pkt(5);

    // len=4 with the buffer reporting empty for five cycles mid-read
    start_pkt(4, 8'h40, 1'b1);
    @(posedge bbClk); #1;
    bufferEmptyFlag = 1'b1;
    repeat (5) @(posedge bbClk);
    #1;
    check("empty_stall_pops", 64'(popDataOutBuffer_p), 64'(0));
    bufferEmptyFlag = 1'b0;
    wait_done(100);
    end_pkt(4);

    // flush after 3 pops of a 12-byte packet, then a clean packet
    start_pkt(12, 8'h50, 1'b0);
    wait_pops(3, 100);
    encrRxBufFlush_p = 1'b1;
    @(posedge bbClk); #1;
    encrRxBufFlush_p = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_valid", 64'(wordValid), 64'(0));
    repeat (5) @(posedge bbClk);
    #1;
    check("flush_pops", 64'(pop_count - pop_mark), 64'(3));
    end_pkt(3);
    start_pkt(8, 8'h60, 1'b1);
    wait_done(100);
    end_pkt(8);

    // zero-length packet completes without pops or words
    start_pkt(0, 8'h00, 1'b1);
    wait_done(20);
    end_pkt(0);

    // flush coincident with start: stays idle
    pop_mark         = pop_count;
    rxPayloadLen     = 16'd4;
    startRead_p      = 1'b1;
    encrRxBufFlush_p = 1'b1;
    @(posedge bbClk); #1;
    startRead_p      = 1'b0;
    encrRxBufFlush_p = 1'b0;
    check("flush_start_busy", 64'(busy), 64'(0));
    repeat (3) @(posedge bbClk);
    #1;
    end_pkt(0);

    // soft reset mid-packet discards it, then a 7-byte packet recovers
    start_pkt(12, 8'h70, 1'b0);
    wait_pops(2, 100);
    softRstBbClk_p = 1'b1;
    @(posedge bbClk); #1;
    softRstBbClk_p = 1'b0;
    check("soft_rst_busy", 64'(busy), 64'(0));
    check("soft_rst_data", 64'(wordData), 64'(0));
    repeat (5) @(posedge bbClk);
    #1;
    end_pkt(2);
    start_pkt(7, 8'h80, 1'b1);
    wait_done(100);
    end_pkt(7);

`ifdef RW_RX_MIC_EXTRACT_EN
    // 12 data bytes in three words, then bytes 12..19 into micData
    start_pkt(20, 8'h00, 1'b1);
    wait_done(200);
    end_pkt(20);
    // too short for a MIC: all 6 bytes go to words and lenError_p pulses
    start_pkt(6, 8'h20, 1'b1);
    wait_done(100);
    end_pkt(6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
